// File: rtl/rvv_backend_alu_pipe_pkg.sv
// Shared types for the RVV ALU issue pipeline: RS uop, ROB result, stage bundle.
// Lane count defaults to `NUM_ALU; the optional flush port is RVV_ALU_PIPE_FLUSH_EN.
`ifndef NUM_ALU
`define NUM_ALU 2
`endif

package rvv_backend_alu_pipe_pkg;

  localparam int LANES_MAX = 4;
  localparam int ROB_W     = 5;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_MAXU
  } alu_op_e;

  typedef struct packed {
    logic [ROB_W-1:0] rob_entry;
    alu_op_e          op;
    logic [31:0]      vs1;
    logic [31:0]      vs2;
  } ALU_RS_t;

  typedef struct packed {
    logic [ROB_W-1:0] rob_entry;
    logic [31:0]      w_data;
  } PU2ROB_t;

  // Sized for the widest legal group; unused upper lanes stay zero.
  typedef struct packed {
    logic [LANES_MAX-1:0]    lane_vld;
    PU2ROB_t [LANES_MAX-1:0] res;
  } ALU_PIPE_STAGE_t;

  function automatic logic is_prefix(input logic [LANES_MAX-1:0] m);
    return (m & (m + LANES_MAX'(1))) == '0;
  endfunction

  function automatic logic is_contig(input logic [LANES_MAX-1:0] m);
    logic [LANES_MAX-1:0] f;
    f = m | (m - LANES_MAX'(1));
    return (m == '0) || (((f + LANES_MAX'(1)) & m) == '0);
  endfunction

endpackage

// File: rtl/rvv_backend_alu_pipe_stage.sv
// One stall-able pipeline stage: load a group, hold it, or drop retired lanes.
// Lane valids reset synchronously; payload is data-only and never reset.
module rvv_backend_alu_pipe_stage
  import rvv_backend_alu_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic [LANES_MAX-1:0] drop_i,
  input  ALU_PIPE_STAGE_t      d_i,
  output ALU_PIPE_STAGE_t      q_o
);

  logic [LANES_MAX-1:0]    vld_q;
  logic [LANES_MAX-1:0]    vld_d;
  PU2ROB_t [LANES_MAX-1:0] res_q;

  always_comb begin
    vld_d = vld_q & ~drop_i;
    if (load_i) vld_d = d_i.lane_vld;
    if (clr_i) vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) vld_q <= '0;
    else vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (load_i) res_q <= d_i.res;
  end

  assign q_o.lane_vld = vld_q;
  assign q_o.res      = res_q;

endmodule

// File: rtl/rvv_backend_alu_unit.sv
// Single-lane combinational ALU: vd = vs2 op vs1.
// Result valid simply follows the issue valid.
module rvv_backend_alu_unit
  import rvv_backend_alu_pipe_pkg::*;
(
  input  logic    alu_uop_valid_i,
  input  ALU_RS_t alu_uop_i,
  output logic    result_valid_o,
  output PU2ROB_t result_o
);

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] r;

  assign a = alu_uop_i.vs2;
  assign b = alu_uop_i.vs1;

  always_comb begin
    r = '0;
    unique case (alu_uop_i.op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_MAXU: r = (a > b) ? a : b;
      default:  r = '0;
    endcase
  end

  assign result_valid_o     = alu_uop_valid_i;
  assign result_o.rob_entry = alu_uop_i.rob_entry;
  assign result_o.w_data    = r;

endmodule

// File: rtl/rvv_backend_alu_pipe.sv
// ALU issue pipeline: pops in-order groups from the RS, retires to the ROB by lane.
// Define RVV_ALU_PIPE_FLUSH_EN to add the flush_rob2alu input.
module rvv_backend_alu_pipe
  import rvv_backend_alu_pipe_pkg::*;
#(
  parameter int NUM_ALU    = `NUM_ALU,
  parameter int ALU_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef RVV_ALU_PIPE_FLUSH_EN
  input  logic                    flush_rob2alu,
`endif
  input  logic [NUM_ALU-1:0]      alu_uop_valid_rs2ex,
  input  ALU_RS_t [NUM_ALU-1:0]   alu_uop_rs2ex,
  output logic [NUM_ALU-1:0]      pop_ex2rs,
  output logic [NUM_ALU-1:0]      result_valid_ex2rob,
  output PU2ROB_t [NUM_ALU-1:0]   result_ex2rob,
  input  logic [NUM_ALU-1:0]      result_ready_rob2alu
);

  localparam int L = ALU_STAGES - 1;

  logic flush;
`ifdef RVV_ALU_PIPE_FLUSH_EN
  assign flush = flush_rob2alu;
`else
  assign flush = 1'b0;
`endif

  ALU_PIPE_STAGE_t stg_q [ALU_STAGES];
  ALU_PIPE_STAGE_t stg_d [ALU_STAGES];
  ALU_PIPE_STAGE_t head_d;

  logic [ALU_STAGES-1:0]   occ;
  logic [ALU_STAGES-1:0]   vac;
  logic [LANES_MAX-1:0]    vld_l;
  logic [LANES_MAX-1:0]    rdy_l;
  logic [LANES_MAX-1:0]    retire;
  logic [LANES_MAX-1:0]    pop_w;
  logic [LANES_MAX-1:0]    unit_vld;
  PU2ROB_t [LANES_MAX-1:0] unit_res;
  logic                    issue_en;
  logic                    lower_ok;

  assign vld_l = stg_q[L].lane_vld;
  assign rdy_l = LANES_MAX'(result_ready_rob2alu);

  // A lane may only retire once every older lane in its group is gone.
  always_comb begin
    retire   = '0;
    lower_ok = 1'b1;
    for (int i = 0; i < LANES_MAX; i++) begin
      retire[i] = lower_ok & vld_l[i] & rdy_l[i] & ~flush;
      lower_ok  = lower_ok & (retire[i] | ~vld_l[i]);
    end
  end

  always_comb begin
    vac    = '0;
    vac[L] = ~|(vld_l & ~retire);
    for (int k = ALU_STAGES - 2; k >= 0; k--) begin
      vac[k] = ~occ[k] | vac[k+1];
    end
  end

  assign issue_en = vac[0];
  assign pop_w    = (issue_en && !flush) ?
                    LANES_MAX'(alu_uop_valid_rs2ex) : '0;

  for (genvar i = 0; i < LANES_MAX; i++) begin : g_lane
    if (i < NUM_ALU) begin : g_unit
      rvv_backend_alu_unit u_unit (
        .alu_uop_valid_i (pop_w[i]),
        .alu_uop_i       (alu_uop_rs2ex[i]),
        .result_valid_o  (unit_vld[i]),
        .result_o        (unit_res[i])
      );
    end else begin : g_pad
      assign unit_vld[i] = 1'b0;
      assign unit_res[i] = '0;
    end
  end

  assign head_d.lane_vld = pop_w;
  assign head_d.res      = unit_res;

  for (genvar k = 0; k < ALU_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stg_d[k] = head_d;
    end else begin : g_body
      assign stg_d[k] = stg_q[k-1];
    end

    assign occ[k] = |stg_q[k].lane_vld;

    rvv_backend_alu_pipe_stage u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (flush),
      .load_i (vac[k]),
      .drop_i ((k == L) ? retire : '0),
      .d_i    (stg_d[k]),
      .q_o    (stg_q[k])
    );
  end

  assign pop_ex2rs           = pop_w[NUM_ALU-1:0];
  assign result_valid_ex2rob = vld_l[NUM_ALU-1:0] & ~{NUM_ALU{flush}};
  assign result_ex2rob       = stg_q[L].res[NUM_ALU-1:0];

  logic unused_ok;
  assign unused_ok = ^{unit_vld, stg_q[L]};

`ifdef ASSERT_ON
  a_unit_vld: assert property (@(posedge clk)
    unit_vld == pop_w);
  a_prefix: assert property (@(posedge clk) disable iff (!rst_n)
    is_prefix(LANES_MAX'(alu_uop_valid_rs2ex)));
  a_suffix: assert property (@(posedge clk) disable iff (!rst_n)
    is_contig(vld_l));
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (!vac[L] && !flush) |=> (vld_l == $past(vld_l & ~retire)));
`endif

endmodule

// File: tb/tb_rvv_backend_alu_pipe.sv
// Self-checking bench for rvv_backend_alu_pipe: directed + random groups
// against a group-position reference model (RVV_ALU_PIPE_FLUSH_EN optional).
module tb_rvv_backend_alu_pipe;
  import rvv_backend_alu_pipe_pkg::*;

  localparam int NA = 2;
  localparam int NS = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NA-1:0]       valid;
  ALU_RS_t [NA-1:0]    uops;
  logic [NA-1:0]       pop;
  logic [NA-1:0]       rv;
  PU2ROB_t [NA-1:0]    res;
  logic [NA-1:0]       ready;
  logic                flush;

  rvv_backend_alu_pipe #(.NUM_ALU(NA), .ALU_STAGES(NS)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
`ifdef RVV_ALU_PIPE_FLUSH_EN
    .flush_rob2alu        (flush),
`endif
    .alu_uop_valid_rs2ex  (valid),
    .alu_uop_rs2ex        (uops),
    .pop_ex2rs            (pop),
    .result_valid_ex2rob  (rv),
    .result_ex2rob        (res),
    .result_ready_rob2alu (ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NA-1:0]    m;
    PU2ROB_t [NA-1:0] r;
    int               pos;
  } grp_t;

  grp_t pipe[$];
  int   checks = 0;
  int   passes = 0;
  int   ctr    = 0;

  function automatic logic [31:0] ref_alu(input alu_op_e op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      default: return (a > b) ? a : b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cycle(input logic [NA-1:0] v, input logic [NA-1:0] rdy,
                       input bit fl);
    logic [NA-1:0]    exp_rv;
    logic [NA-1:0]    exp_pop;
    logic [NA-1:0]    ret;
    logic [NA-1:0]    left;
    PU2ROB_t [NA-1:0] hr;
    bit               ok;
    int               limit;
    grp_t             g;
    for (int i = 0; i < NA; i++) begin
      uops[i].rob_entry = ROB_W'(ctr + i);
      uops[i].op        = alu_op_e'(3'($urandom_range(0, 7)));
      uops[i].vs1       = $urandom;
      uops[i].vs2       = $urandom;
    end
    valid = v;
    ready = rdy;
    flush = fl;
    #4;
    exp_rv = '0;
    hr     = '0;
    if (!fl && pipe.size() > 0 && pipe[0].pos == NS - 1) begin
      exp_rv = pipe[0].m;
      hr     = pipe[0].r;
    end
    ret = '0;
    ok  = 1'b1;
    for (int i = 0; i < NA; i++) begin
      if (exp_rv[i]) begin
        if (ok && rdy[i]) ret[i] = 1'b1;
        else ok = 1'b0;
      end
    end
    left = exp_rv & ~ret;
    if (fl) pipe.delete();
    else begin
      if (exp_rv != '0) begin
        if (left == '0) void'(pipe.pop_front());
        else pipe[0].m = left;
      end
      for (int j = 0; j < pipe.size(); j++) begin
        limit = (j == 0) ? NS - 1 : pipe[j-1].pos - 1;
        if (pipe[j].pos < limit) pipe[j].pos++;
      end
    end
    exp_pop = '0;
    if (!fl && (pipe.size() == 0 || pipe[$].pos > 0)) exp_pop = v;
    chk("pop", 64'(pop), 64'(exp_pop));
    chk("result_valid", 64'(rv), 64'(exp_rv));
    for (int i = 0; i < NA; i++)
      if (exp_rv[i]) chk("result_data", 64'(res[i]), 64'(hr[i]));
    if (exp_pop != '0) begin
      g.m   = exp_pop;
      g.pos = 0;
      for (int i = 0; i < NA; i++) begin
        g.r[i].rob_entry = uops[i].rob_entry;
        g.r[i].w_data    = ref_alu(uops[i].op, uops[i].vs2, uops[i].vs1);
      end
      pipe.push_back(g);
    end
    ctr += $countones(exp_pop);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [NA-1:0] v);
    rst_n = 1'b0;
    valid = v;
    ready = '1;
    flush = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pipe.delete();
  endtask

  initial begin
    logic [NA-1:0] vm;
    logic [NA-1:0] rm;
    rst_n = 1'b0;
    valid = '0;
    ready = '0;
    flush = 1'b0;
    uops  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state and a single group
    cycle('0, '1, 0);
    cycle(2'b11, 2'b11, 0);
    repeat (3) cycle('0, 2'b11, 0);

    // steady stream
    repeat (8) cycle(2'b11, 2'b11, 0);

    // backpressure then resume
    repeat (5) cycle(2'b11, 2'b00, 0);
    repeat (6) cycle(2'b11, 2'b11, 0);
    repeat (3) cycle('0, 2'b11, 0);

    // partial retire
    cycle(2'b11, 2'b00, 0);
    cycle('0, 2'b00, 0);
    cycle('0, 2'b10, 0);
    cycle('0, 2'b01, 0);
    cycle(2'b11, 2'b00, 0);
    cycle('0, 2'b10, 0);
    repeat (3) cycle('0, 2'b11, 0);

    // odd group
    cycle(2'b01, 2'b11, 0);
    repeat (3) cycle('0, 2'b11, 0);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      vm = NA'((1 << $urandom_range(0, NA)) - 1);
      rm = NA'($urandom);
      cycle(vm, rm, 0);
    end
    repeat (4) cycle('0, '1, 0);

    // reset with groups in flight
    cycle(2'b11, 2'b00, 0);
    cycle(2'b11, 2'b00, 0);
    do_reset(2'b11);
    repeat (3) cycle('0, 2'b11, 0);
    cycle(2'b11, 2'b11, 0);
    repeat (3) cycle('0, 2'b11, 0);

`ifdef RVV_ALU_PIPE_FLUSH_EN
    cycle(2'b11, 2'b00, 0);
    cycle(2'b11, 2'b00, 0);
    cycle(2'b11, 2'b11, 1);
    repeat (2) cycle('0, 2'b11, 0);
    cycle(2'b11, 2'b11, 0);
    repeat (3) cycle('0, 2'b11, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
